// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with per-key debounce
// and a show-ahead press/release event FIFO.
module keypad_scan_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n_o,
    input  logic [3:0] col_n_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [3:0] evt_code_o,
    output logic       evt_press_o,
    output logic       overflow_o,
    input  logic       clr_ovf_i
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DEB_SCANS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {SCAN_WAIT, SAMPLE, EMIT} state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [1:0]             row_q, row_d;
    logic [15:0]            key_q, key_d;
    logic [15:0][CW-1:0]    cnt_q, cnt_d;
    logic [3:0]             emit_q, emit_d;
    logic [1:0]             sel;
    logic                   push;
    logic [4:0]             push_data;

    logic [4:0]             mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q, rptr_d;
    logic [NW-1:0]          count_q, count_d;
    logic [4:0]             head_q, head_d;
    logic                   ovf_q, ovf_d;
    logic                   pop, full, push_ok;

    assign row_n_o     = ~(4'b0001 << row_q);
    assign evt_valid_o = (count_q != '0);
    assign evt_code_o  = head_q[4:1];
    assign evt_press_o = head_q[0];
    assign overflow_o  = ovf_q;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        row_d     = row_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        emit_d    = emit_q;
        push      = 1'b0;
        push_data = '0;
        sel       = '0;
        for (int c = 3; c >= 0; c--) begin
            if (emit_q[c]) sel = 2'(c);
        end
        unique case (state_q)
            SCAN_WAIT: begin
                if (tick_q == TW'(CLK_DIV - 1)) begin
                    tick_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            SAMPLE: begin
                emit_d = '0;
                for (int c = 0; c < 4; c++) begin
                    if (~col_n_i[c] == key_q[{row_q, 2'(c)}]) begin
                        cnt_d[{row_q, 2'(c)}] = '0;
                    end else if (cnt_q[{row_q, 2'(c)}] == CW'(DEB_SCANS - 1)) begin
                        key_d[{row_q, 2'(c)}] = ~col_n_i[c];
                        cnt_d[{row_q, 2'(c)}] = '0;
                        emit_d[c]             = 1'b1;
                    end else begin
                        cnt_d[{row_q, 2'(c)}] = cnt_q[{row_q, 2'(c)}] + 1'b1;
                    end
                end
                if (emit_d != '0) begin
                    state_d = EMIT;
                end else begin
                    state_d = SCAN_WAIT;
                    row_d   = row_q + 2'd1;
                end
            end
            EMIT: begin
                push      = 1'b1;
                push_data = {row_q, sel, key_q[{row_q, sel}]};
                emit_d    = emit_q & (emit_q - 4'd1);
                if (emit_d == '0) begin
                    state_d = SCAN_WAIT;
                    row_d   = row_q + 2'd1;
                end
            end
            default: state_d = SCAN_WAIT;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        pop     = evt_valid_o && evt_ready_i;
        full    = (count_q == NW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + NW'(push_ok) - NW'(pop);
        if (count_d == '0) begin
            head_d = head_q;
        end else if (count_q == NW'(pop)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rptr_d];
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN_WAIT;
            tick_q  <= '0;
            row_q   <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            emit_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            row_q   <= row_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            emit_q  <= emit_d;
            wptr_q  <= wptr_q + PW'(push_ok);
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model,
// event scoreboard and directed scan/debounce scenarios.
module tb_keypad_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [3:0] evt_code;
    logic       evt_press;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    logic [15:0] pressed = '0;
    logic [15:0] model   = '0;
    logic [4:0]  sb [$];
    int checks = 0;
    int fails  = 0;

    keypad_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .row_n_o    (row_n),
        .col_n_i    (col_n),
        .evt_valid_o(evt_valid),
        .evt_ready_i(evt_ready),
        .evt_code_o (evt_code),
        .evt_press_o(evt_press),
        .overflow_o (overflow),
        .clr_ovf_i  (clr_ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && pressed[4*r+c]) col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            logic [4:0] e;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got code=%0d press=%0b, required none",
                         evt_code, evt_press);
            end else begin
                e = sb.pop_front();
                if ({evt_code, evt_press} !== e) begin
                    fails++;
                    $display("FAIL event: got code=%0d press=%0b, required code=%0d press=%0b",
                             evt_code, evt_press, e[4:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_row(input bit eq, output int len);
        len = 0;
        while (((row_n == 4'b1101) != eq) && len < 200) begin
            cyc();
            len++;
        end
        if (len >= 200) begin
            checks++;
            fails++;
            $display("FAIL row_timeout: got row_n=%b, required row 1 %s", row_n,
                     eq ? "entered" : "left");
        end
    endtask

    task automatic row1_ends(input int n, output int len);
        int t;
        len = 0;
        repeat (n) begin
            wait_row(1'b1, t);
            wait_row(1'b0, len);
        end
    endtask

    task automatic expect_change(input logic [15:0] nk);
        int n;
        int len;
        n = 0;
        pressed = nk;
        for (int c = 0; c < 4; c++) begin
            if (nk[4+c] != model[4+c]) begin
                sb.push_back({4'(4 + c), nk[4+c]});
                n++;
            end
        end
        model = nk;
        row1_ends(2, len);
        check("no_early_event", {31'd0, evt_valid}, 32'd0);
        check("pending_before_3rd", sb.size(), n);
        row1_ends(1, len);
        if (n > 0) check("row1_period", len, 5 + n);
        repeat (n + 2) cyc();
        check("events_drained", sb.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_row_n", {28'd0, row_n}, 32'hE);
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_code", {28'd0, evt_code}, 0);
        check("rst_press", {31'd0, evt_press}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
    endtask

    initial begin
        int len;
        logic [3:0] exp_row;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            exp_row = ~(4'b0001 << ((i / 5) % 4));
            check("row_seq", {28'd0, row_n}, {28'd0, exp_row});
            if (evt_valid) check("idle_valid", 1, 0);
            cyc();
        end

        expect_change(16'h0040);
        expect_change(16'h0000);
        row1_ends(4, len);
        check("no_further_events", sb.size(), 0);

        pressed = 16'h0040;
        row1_ends(2, len);
        pressed = 16'h0000;
        row1_ends(1, len);
        repeat (3) cyc();
        check("glitch_no_event", {31'd0, evt_valid}, 0);
        expect_change(16'h0040);
        expect_change(16'h0000);

        expect_change(16'h00B0);
        expect_change(16'h0000);

        evt_ready = 1'b0;
        pressed = 16'h00F0;
        for (int c = 0; c < 4; c++) sb.push_back({4'(4 + c), 1'b1});
        model = 16'h00F0;
        row1_ends(3, len);
        check("fill_valid", {31'd0, evt_valid}, 1);
        check("fill_head_code", {28'd0, evt_code}, 4);
        check("fill_no_ovf", {31'd0, overflow}, 0);
        pressed = 16'h00E0;
        model = 16'h00E0;
        row1_ends(3, len);
        check("ovf_set", {31'd0, overflow}, 1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 0);
        evt_ready = 1'b1;
        repeat (6) cyc();
        check("fifo_drained", sb.size(), 0);
        check("drained_valid", {31'd0, evt_valid}, 0);

        expect_change(16'h0000);
        evt_ready = 1'b0;
        pressed = 16'h00B0;
        row1_ends(2, len);
        wait_row(1'b1, len);
        repeat (6) cyc();
        check("emit_head_valid", {31'd0, evt_valid}, 1);
        check("emit_head_code", {28'd0, evt_code}, 4);
        rst = 1'b1;
        #1;
        check_reset_vals();
        cyc();
        rst = 1'b0;
        model = '0;
        evt_ready = 1'b1;
        expect_change(16'h00B0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
